// File: rtl/cpu16_pkg.sv
// Shared definitions for the CPU16 datapath: default data width, status flag bit
// positions and the adder-sharing sequencer states.
package cpu16_pkg;

    localparam int DATA_W_DEFAULT = 16;

    // Bit positions inside the 4-bit {N,P,Z,C} status word
    localparam int FLAG_N = 3;
    localparam int FLAG_P = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        WB   = 2'd2
    } state_e;

    localparam logic PORT_EXEC = 1'b0;
    localparam logic PORT_AGEN = 1'b1;

endpackage : cpu16_pkg

// File: rtl/status_flag_calc.sv
// Combinational flag encoder: turns an adder result into {N,P,Z,C}.
// With STATUS_OVF_EN defined the signed-overflow bit is passed through as v.
module status_flag_calc
    import cpu16_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic [DATA_W-1:0] sum,
    input  logic              carry,
`ifdef STATUS_OVF_EN
    input  logic              ovf,
    output logic              v,
`endif
    output logic [3:0]        flags
);

    logic neg;
    logic zero;

    always_comb begin
        neg   = sum[DATA_W-1];
        zero  = (sum == '0);
        flags = 4'b0000;
        // N, P and Z are mutually exclusive; C is independent of the sign class
        flags[FLAG_N] = neg;
        flags[FLAG_P] = ~neg & ~zero;
        flags[FLAG_Z] = zero;
        flags[FLAG_C] = carry;
    end

`ifdef STATUS_OVF_EN
    assign v = ovf;
`endif

endmodule : status_flag_calc

// File: rtl/adder_share_arbiter.sv
// Shares one adder and flag encoder between the execute stage (port 0) and the
// address generator (port 1); owns status_reg. STATUS_OVF_EN adds status_v.
module adder_share_arbiter
    import cpu16_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [DATA_W-1:0] r0_a,
    input  logic [DATA_W-1:0] r0_b,
    input  logic              r0_sub,
    input  logic              r0_upd,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [DATA_W-1:0] r1_a,
    input  logic [DATA_W-1:0] r1_b,
    output logic              rsp0_valid,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp_sum,
    output logic [3:0]        status_reg
`ifdef STATUS_OVF_EN
    ,
    output logic              status_v
`endif
);

    // Handshake: a request transfers on a rising edge where valid && ready. Ready is
    // a grant (depends on valid), only offered in IDLE; responses cannot be stalled.

    state_e            state_q, state_d;
    logic              prio_q, prio_d;      // port preferred when both request
    logic              port_q, port_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic              sub_q, sub_d;
    logic              upd_q, upd_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              carry_q, carry_d;
    logic              rsp0_valid_q, rsp0_valid_d;
    logic              rsp1_valid_q, rsp1_valid_d;
    logic [3:0]        status_q, status_d;
`ifdef STATUS_OVF_EN
    logic              ovf_q, ovf_d;
    logic              status_v_q, status_v_d;
    logic              ovf_c;
    logic              flag_v;
`endif

    logic              grant0;
    logic              grant1;
    logic              in_idle;
    logic [DATA_W-1:0] b_eff;
    logic [DATA_W:0]   add_c;
    logic [3:0]        flags;

    // Arbitration and grant
    always_comb begin
        in_idle  = (state_q == IDLE);
        grant0   = r0_valid & (~r1_valid | (prio_q == PORT_EXEC));
        grant1   = r1_valid & (~r0_valid | (prio_q == PORT_AGEN));
        r0_ready = in_idle & ~rst & grant0;
        r1_ready = in_idle & ~rst & grant1;
    end

    // Shared adder: subtraction as A + ~B + 1
    always_comb begin
        b_eff = sub_q ? ~b_q : b_q;
        add_c = {1'b0, a_q} + {1'b0, b_eff} + {{DATA_W{1'b0}}, sub_q};
`ifdef STATUS_OVF_EN
        ovf_c = (a_q[DATA_W-1] == b_eff[DATA_W-1]) & (add_c[DATA_W-1] != a_q[DATA_W-1]);
`endif
    end

    status_flag_calc #(
        .DATA_W (DATA_W)
    ) u_flags (
        .sum   (sum_q),
        .carry (carry_q),
`ifdef STATUS_OVF_EN
        .ovf   (ovf_q),
        .v     (flag_v),
`endif
        .flags (flags)
    );

    always_comb begin
        state_d      = state_q;
        prio_d       = prio_q;
        port_d       = port_q;
        a_d          = a_q;
        b_d          = b_q;
        sub_d        = sub_q;
        upd_d        = upd_q;
        sum_d        = sum_q;
        carry_d      = carry_q;
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        status_d     = status_q;
`ifdef STATUS_OVF_EN
        ovf_d        = ovf_q;
        status_v_d   = status_v_q;
`endif

        case (state_q)
            IDLE: begin
                if (r0_valid & r0_ready) begin
                    port_d  = PORT_EXEC;
                    a_d     = r0_a;
                    b_d     = r0_b;
                    sub_d   = r0_sub;
                    upd_d   = r0_upd;
                    prio_d  = PORT_AGEN;
                    state_d = CALC;
                end else if (r1_valid & r1_ready) begin
                    // Address generation is add-only and never touches status
                    port_d  = PORT_AGEN;
                    a_d     = r1_a;
                    b_d     = r1_b;
                    sub_d   = 1'b0;
                    upd_d   = 1'b0;
                    prio_d  = PORT_EXEC;
                    state_d = CALC;
                end
            end

            CALC: begin
                sum_d        = add_c[DATA_W-1:0];
                carry_d      = add_c[DATA_W];
`ifdef STATUS_OVF_EN
                ovf_d        = ovf_c;
`endif
                rsp0_valid_d = (port_q == PORT_EXEC);
                rsp1_valid_d = (port_q == PORT_AGEN);
                state_d      = WB;
            end

            WB: begin
                if ((port_q == PORT_EXEC) && upd_q) begin
                    status_d = flags;
`ifdef STATUS_OVF_EN
                    status_v_d = flag_v;
`endif
                end
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            prio_q       <= PORT_EXEC;
            port_q       <= PORT_EXEC;
            a_q          <= '0;
            b_q          <= '0;
            sub_q        <= 1'b0;
            upd_q        <= 1'b0;
            sum_q        <= '0;
            carry_q      <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            status_q     <= 4'b0000;
`ifdef STATUS_OVF_EN
            ovf_q        <= 1'b0;
            status_v_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            prio_q       <= prio_d;
            port_q       <= port_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sub_q        <= sub_d;
            upd_q        <= upd_d;
            sum_q        <= sum_d;
            carry_q      <= carry_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            status_q     <= status_d;
`ifdef STATUS_OVF_EN
            ovf_q        <= ovf_d;
            status_v_q   <= status_v_d;
`endif
        end
    end

    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp_sum    = sum_q;
    assign status_reg = status_q;
`ifdef STATUS_OVF_EN
    assign status_v   = status_v_q;
`endif

endmodule : adder_share_arbiter
